// File: rtl/matrix_pkg.sv
// matrix_pkg: definitions shared across the matrix-multiplier blocks.
//   DEFAULT_DATA_W : default operand word width in bits
//   sel_width()    : index width for a bank of 'depth' entries, clog2 with a
//                    floor of one bit so single-entry banks still get a port
package matrix_pkg;

  localparam int DEFAULT_DATA_W = 16;

  function automatic int sel_width(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/operand_bank.sv
// operand_bank: one operand channel of the matrix operand loader. It holds
// DEPTH element registers, a per-element written mask, a sequential fill
// pointer and a sticky out-of-range index flag.
//   clk, rst   : clock, synchronous active-high reset
//   clear      : synchronous clear of registers, mask, pointer and flag
//   seq_mode   : 1 = fill at the internal pointer, 0 = fill at sel
//   valid/ready: write handshake; a write happens on valid && ready
//   sel, data  : element index (addressed mode only) and write data
//   regs       : flattened bank, element i at [i*DATA_W +: DATA_W]
//   full       : every element written since the last clear/reset
//   err        : sticky, set by an addressed write with sel >= DEPTH
module operand_bank
  import matrix_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEPTH  = 4,
  localparam int SEL_W = sel_width(DEPTH),
  localparam int PTR_W = sel_width(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    seq_mode,
  input  logic                    valid,
  input  logic [SEL_W-1:0]        sel,
  input  logic [DATA_W-1:0]       data,
  output logic                    ready,
  output logic [DEPTH*DATA_W-1:0] regs,
  output logic                    full,
  output logic                    err
);

  // The pointer needs one extra code so it can park at DEPTH after the last
  // sequential write instead of wrapping onto element 0.
  localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(DEPTH);

  logic [DEPTH-1:0][DATA_W-1:0] mem_p0;
  logic [DEPTH-1:0]             mask_p0;
  logic [PTR_W-1:0]             ptr_p0;
  logic                         err_p0;

  logic             wr_fire;
  logic             wr_en;
  logic             ptr_inc;
  logic             sel_bad;
  logic [SEL_W-1:0] wr_idx;

  assign full    = &mask_p0;
  assign regs    = mem_p0;
  assign err     = err_p0;
  // In sequential mode a parked pointer implies a full mask, so !full is
  // sufficient to block writes past the end.
  assign ready   = !rst && !clear && (seq_mode ? !full : 1'b1);
  assign wr_fire = valid && ready;

  always_comb begin
    wr_en   = 1'b0;
    ptr_inc = 1'b0;
    sel_bad = 1'b0;
    wr_idx  = '0;
    if (wr_fire) begin
      if (seq_mode) begin
        if (ptr_p0 < PTR_MAX) begin
          wr_en   = 1'b1;
          ptr_inc = 1'b1;
          wr_idx  = SEL_W'(ptr_p0);
        end
      end else if (PTR_W'(sel) >= PTR_MAX) begin
        sel_bad = 1'b1;
      end else begin
        wr_en  = 1'b1;
        wr_idx = sel;
      end
    end
  end

  // Stage p0: element registers, written mask, fill pointer, error flag
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      mem_p0  <= '0;
      mask_p0 <= '0;
      ptr_p0  <= '0;
      err_p0  <= 1'b0;
    end else begin
      if (wr_en) begin
        mem_p0[wr_idx]  <= data;
        mask_p0[wr_idx] <= 1'b1;
      end
      if (ptr_inc) begin
        ptr_p0 <= ptr_p0 + PTR_W'(1);
      end
      if (sel_bad) begin
        err_p0 <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/matrix_operand_loader.sv
// matrix_operand_loader: loads the A and B operand banks of the matrix
// multiplier through two independent write channels.
//   clk, rst          : clock, synchronous active-high reset
//   seq_mode          : 1 = sequential fill, 0 = addressed fill via *_sel
//   clear             : synchronous clear of both banks, pointers and flags
//   a_valid/a_ready   : A write handshake, a_sel/a_data index and data
//   b_valid/b_ready   : B write handshake, b_sel/b_data index and data
//   a_regs, b_regs    : flattened banks, element i at [i*DATA_W +: DATA_W]
//   a_full, b_full    : bank completely written since last clear/reset
//   load_done         : one-cycle pulse after both banks first become full
//   sel_err           : sticky out-of-range addressed write on either bank
module matrix_operand_loader
  import matrix_pkg::*;
#(
  parameter int DATA_W  = DEFAULT_DATA_W,
  parameter int A_DEPTH = 4,
  parameter int B_DEPTH = 8,
  localparam int A_SEL_W = sel_width(A_DEPTH),
  localparam int B_SEL_W = sel_width(B_DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      seq_mode,
  input  logic                      clear,
  input  logic                      a_valid,
  input  logic [A_SEL_W-1:0]        a_sel,
  input  logic [DATA_W-1:0]         a_data,
  output logic                      a_ready,
  input  logic                      b_valid,
  input  logic [B_SEL_W-1:0]        b_sel,
  input  logic [DATA_W-1:0]         b_data,
  output logic                      b_ready,
  output logic [A_DEPTH*DATA_W-1:0] a_regs,
  output logic [B_DEPTH*DATA_W-1:0] b_regs,
  output logic                      a_full,
  output logic                      b_full,
  output logic                      load_done,
  output logic                      sel_err
);

  logic a_err;
  logic b_err;
  logic both_full;
  logic done_seen_p1;

  operand_bank #(
    .DATA_W(DATA_W),
    .DEPTH (A_DEPTH)
  ) u_a_bank (
    .clk     (clk),
    .rst     (rst),
    .clear   (clear),
    .seq_mode(seq_mode),
    .valid   (a_valid),
    .sel     (a_sel),
    .data    (a_data),
    .ready   (a_ready),
    .regs    (a_regs),
    .full    (a_full),
    .err     (a_err)
  );

  operand_bank #(
    .DATA_W(DATA_W),
    .DEPTH (B_DEPTH)
  ) u_b_bank (
    .clk     (clk),
    .rst     (rst),
    .clear   (clear),
    .seq_mode(seq_mode),
    .valid   (b_valid),
    .sel     (b_sel),
    .data    (b_data),
    .ready   (b_ready),
    .regs    (b_regs),
    .full    (b_full),
    .err     (b_err)
  );

  assign both_full = a_full && b_full;
  assign sel_err   = a_err | b_err;

  // Stage p1: edge detect on both_full; done_seen_p1 suppresses repeats
  // (e.g. after an overwrite) until the next clear/reset.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      load_done    <= 1'b0;
      done_seen_p1 <= 1'b0;
    end else begin
      load_done <= both_full && !done_seen_p1;
      if (both_full) begin
        done_seen_p1 <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_matrix_operand_loader.sv
module tb_matrix_operand_loader;

  localparam int AD = 4;
  localparam int BD = 8;

  logic         clk = 1'b0;
  logic         rst, seq_mode, clear;
  logic         a_valid, b_valid;
  logic [1:0]   a_sel;
  logic [2:0]   b_sel;
  logic [15:0]  a_data, b_data;
  logic         a_ready, b_ready, a_full, b_full, load_done, sel_err;
  logic [63:0]  a_regs;
  logic [127:0] b_regs;
  logic         a_ready6, b_ready6, a_full6, b_full6, load_done6, sel_err6;
  logic [63:0]  a_regs6;
  logic [95:0]  b_regs6;

  always #5 clk = ~clk;

  matrix_operand_loader #(.DATA_W(16), .A_DEPTH(AD), .B_DEPTH(BD)) dut (
    .clk(clk), .rst(rst), .seq_mode(seq_mode), .clear(clear),
    .a_valid(a_valid), .a_sel(a_sel), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_sel(b_sel), .b_data(b_data), .b_ready(b_ready),
    .a_regs(a_regs), .b_regs(b_regs), .a_full(a_full), .b_full(b_full),
    .load_done(load_done), .sel_err(sel_err)
  );

  // Second instance with a non-power-of-two B bank for out-of-range indices.
  matrix_operand_loader #(.DATA_W(16), .A_DEPTH(AD), .B_DEPTH(6)) dut6 (
    .clk(clk), .rst(rst), .seq_mode(seq_mode), .clear(clear),
    .a_valid(a_valid), .a_sel(a_sel), .a_data(a_data), .a_ready(a_ready6),
    .b_valid(b_valid), .b_sel(b_sel), .b_data(b_data), .b_ready(b_ready6),
    .a_regs(a_regs6), .b_regs(b_regs6), .a_full(a_full6), .b_full(b_full6),
    .load_done(load_done6), .sel_err(sel_err6)
  );

  typedef struct {
    bit          rst, clr, seq, av, bv;
    logic [1:0]  asel;
    logic [2:0]  bsel;
    logic [15:0] ad, bd;
    bit          e_ar, e_br, e_af, e_bf, e_ld;
  } vec_t;

  // Reference model of the default-parameter instance
  logic [15:0] ma[AD];
  bit          mwa[AD];
  int          mpa;
  logic [15:0] mb[BD];
  bit          mwb[BD];
  int          mpb;
  bit          merr, mld, mseen;

  int tests = 0;
  int fails = 0;
  bit last_ar, last_br;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic bit full_a();
    int n = 0;
    for (int i = 0; i < AD; i++) n += mwa[i];
    return n == AD;
  endfunction

  function automatic bit full_b();
    int n = 0;
    for (int i = 0; i < BD; i++) n += mwb[i];
    return n == BD;
  endfunction

  function automatic logic [63:0] pack_a();
    logic [63:0] v;
    for (int i = 0; i < AD; i++) v[i*16 +: 16] = ma[i];
    return v;
  endfunction

  function automatic logic [127:0] pack_b();
    logic [127:0] v;
    for (int i = 0; i < BD; i++) v[i*16 +: 16] = mb[i];
    return v;
  endfunction

  task automatic model_edge();
    bit both;
    both = full_a() && full_b();
    if (rst || clear) begin
      for (int i = 0; i < AD; i++) begin ma[i] = '0; mwa[i] = 1'b0; end
      for (int i = 0; i < BD; i++) begin mb[i] = '0; mwb[i] = 1'b0; end
      mpa = 0; mpb = 0; merr = 0; mld = 0; mseen = 0;
    end else begin
      mld = both && !mseen;
      if (both) mseen = 1;
      if (a_valid) begin
        if (seq_mode) begin
          if (!full_a() && mpa < AD) begin ma[mpa] = a_data; mwa[mpa] = 1; mpa++; end
        end else if (int'(a_sel) < AD) begin
          ma[a_sel] = a_data; mwa[a_sel] = 1;
        end else merr = 1;
      end
      if (b_valid) begin
        if (seq_mode) begin
          if (!full_b() && mpb < BD) begin mb[mpb] = b_data; mwb[mpb] = 1; mpb++; end
        end else if (int'(b_sel) < BD) begin
          mb[b_sel] = b_data; mwb[b_sel] = 1;
        end else merr = 1;
      end
    end
  endtask

  task automatic drive(input bit r, input bit c, input bit s,
                       input bit av, input logic [1:0] as, input logic [15:0] ad,
                       input bit bv, input logic [2:0] bs, input logic [15:0] bd);
    rst = r; clear = c; seq_mode = s;
    a_valid = av; a_sel = as; a_data = ad;
    b_valid = bv; b_sel = bs; b_data = bd;
  endtask

  task automatic idle();
    drive(0, 0, seq_mode, 0, 2'd0, 16'd0, 0, 3'd0, 16'd0);
  endtask

  // One clock: readies checked before the edge, state checked after it.
  task automatic step();
    bit ear, ebr;
    #1;
    ear = !rst && !clear && (seq_mode ? !full_a() : 1'b1);
    ebr = !rst && !clear && (seq_mode ? !full_b() : 1'b1);
    last_ar = a_ready;
    last_br = b_ready;
    chk("a_ready", a_ready, ear);
    chk("b_ready", b_ready, ebr);
    @(posedge clk);
    model_edge();
    #1;
    chk("a_regs", a_regs, pack_a());
    chk("b_regs", b_regs, pack_b());
    chk("a_full", a_full, full_a());
    chk("b_full", b_full, full_b());
    chk("load_done", load_done, mld);
    chk("sel_err", sel_err, merr);
  endtask

  task automatic full_load();
    for (int i = 0; i < BD; i++) begin
      drive(0, 0, 0, i < AD, 2'(i), 16'(i + 1), 1, 3'(i), 16'(10 + i));
      step();
    end
    idle();
  endtask

  vec_t tbl[$];
  vec_t v;
  bit   found;

  initial begin
    for (int i = 0; i < AD; i++) begin ma[i] = '0; mwa[i] = 0; end
    for (int i = 0; i < BD; i++) begin mb[i] = '0; mwb[i] = 0; end
    mpa = 0; mpb = 0; merr = 0; mld = 0; mseen = 0;
    drive(1, 0, 0, 0, 2'd0, 16'd0, 0, 3'd0, 16'd0);

    // Reset then addressed full load, expectations derived by hand
    for (int i = 0; i < 11; i++) begin
      v = '{default: 0};
      if (i == 0) v.rst = 1;
      else if (i <= 8) begin
        v.bv = 1; v.bsel = 3'(i - 1); v.bd = 16'(10 + i - 1);
        if (i <= 4) begin v.av = 1; v.asel = 2'(i - 1); v.ad = 16'(i); end
      end
      v.e_ar = (i != 0); v.e_br = (i != 0);
      v.e_af = (i >= 4); v.e_bf = (i >= 8); v.e_ld = (i == 9);
      tbl.push_back(v);
    end
    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].clr, tbl[i].seq, tbl[i].av, tbl[i].asel, tbl[i].ad,
            tbl[i].bv, tbl[i].bsel, tbl[i].bd);
      step();
      chk($sformatf("tbl%0d_a_ready", i), last_ar, tbl[i].e_ar);
      chk($sformatf("tbl%0d_b_ready", i), last_br, tbl[i].e_br);
      chk($sformatf("tbl%0d_a_full", i), a_full, tbl[i].e_af);
      chk($sformatf("tbl%0d_b_full", i), b_full, tbl[i].e_bf);
      chk($sformatf("tbl%0d_load_done", i), load_done, tbl[i].e_ld);
    end
    chk("load_a_regs", a_regs, 64'h0004_0003_0002_0001);
    chk("load_b_regs", b_regs, 128'h0011_0010_000f_000e_000d_000c_000b_000a);

    // Simultaneous A/B writes including an overwrite of A[1]
    drive(0, 0, 0, 1, 2'd1, 16'hFFFF, 1, 3'd5, 16'h0055);
    step();
    chk("ovr_a_regs", a_regs, 64'h0004_0003_FFFF_0001);
    chk("ovr_b_regs", b_regs, 128'h0011_0010_0055_000e_000d_000c_000b_000a);
    chk("ovr_a_full", a_full, 1'b1);
    chk("ovr_no_load_done", load_done, 1'b0);
    idle();
    for (int i = 0; i < 2; i++) begin
      step();
      chk("ovr_no_load_done_later", load_done, 1'b0);
    end

    // Clear together with a write to A[2]
    drive(0, 1, 0, 1, 2'd2, 16'hABCD, 0, 3'd0, 16'd0);
    step();
    chk("clr_a_ready", last_ar, 1'b0);
    chk("clr_a_regs", a_regs, 64'd0);
    chk("clr_b_regs", b_regs, 128'd0);
    chk("clr_a_full", a_full, 1'b0);
    for (int i = 0; i < AD; i++) begin
      drive(0, 0, 0, 1, 2'(i), 16'(16'h20 + i), 0, 3'd0, 16'd0);
      step();
      chk($sformatf("clr_mask_a_full%0d", i), a_full, i == AD - 1);
    end
    idle();

    // Sequential fill: five back-to-back A writes
    drive(0, 1, 0, 0, 2'd0, 16'd0, 0, 3'd0, 16'd0);
    step();
    for (int k = 0; k < 5; k++) begin
      drive(0, 0, 1, 1, 2'd0, 16'(16'h100 + k), 0, 3'd0, 16'd0);
      step();
      chk($sformatf("seq_a_ready%0d", k), last_ar, k < 4);
    end
    chk("seq_a3", a_regs[63:48], 16'h0103);
    chk("seq_a_full", a_full, 1'b1);
    step();
    chk("seq_a_ready_parked", last_ar, 1'b0);
    idle();
    seq_mode = 0;

    // Out-of-range index on a 6-deep B bank
    drive(0, 1, 0, 0, 2'd0, 16'd0, 0, 3'd0, 16'd0);
    step();
    drive(0, 0, 0, 0, 2'd0, 16'd0, 1, 3'd0, 16'h0077);
    step();
    drive(0, 0, 0, 0, 2'd0, 16'd0, 1, 3'd7, 16'h0099);
    step();
    chk("oor_b_regs6", b_regs6, 96'h0077);
    chk("oor_sel_err6", sel_err6, 1'b1);
    idle();
    for (int i = 0; i < 3; i++) begin
      step();
      chk("oor_sel_err6_held", sel_err6, 1'b1);
    end
    drive(0, 1, 0, 0, 2'd0, 16'd0, 0, 3'd0, 16'd0);
    step();
    chk("oor_sel_err6_cleared", sel_err6, 1'b0);
    chk("oor_b_regs6_cleared", b_regs6, 96'd0);

    // Reset mid-load after three writes, then a complete load
    drive(0, 0, 0, 1, 2'd0, 16'h1111, 1, 3'd0, 16'h2222);
    step();
    drive(0, 0, 0, 1, 2'd1, 16'h3333, 0, 3'd0, 16'd0);
    step();
    drive(1, 0, 0, 1, 2'd2, 16'h4444, 1, 3'd1, 16'h5555);
    step();
    chk("rst_a_ready", last_ar, 1'b0);
    chk("rst_a_regs", a_regs, 64'd0);
    chk("rst_b_regs", b_regs, 128'd0);
    chk("rst_flags", {a_full, b_full, load_done, sel_err}, 4'b0000);
    full_load();
    found = 0;
    for (int i = 0; i < 4 && !found; i++) begin
      step();
      if (load_done) found = 1;
    end
    chk("rst_reload_load_done", found, 1'b1);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      drive(($urandom % 60) == 0, ($urandom % 25) == 0, ($urandom % 3) == 0,
            ($urandom % 3) != 0, 2'($urandom), 16'($urandom),
            ($urandom % 3) != 0, 3'($urandom), 16'($urandom));
      step();
    end
    idle();
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
